// File: rtl/register_rename_unit.sv
// register_rename_unit
//   Rename stage between decode and issue. Maps architectural source and
//   destination registers onto physical registers through a speculative map,
//   allocates destinations from a free list, and tracks a retirement map that
//   commit updates. A flush restores the speculative map from the retirement
//   map and rebuilds the free list in one cycle. Architectural r0 is never
//   renamed and always maps to physical 0.
//
// Ports
//   clk, rst_n                     clock (rising edge), async active-low reset
//   in_valid / in_ready            decoded instruction handshake
//   uses_rs/rt/rw, rs/rt/rw_addr   operand-use bits and architectural addresses
//   out_rs_phys / out_rt_phys      source mappings (0 when unused)
//   out_rw_phys                    newly allocated destination (0 if none)
//   out_prev_phys                  previous mapping of rw_addr
//   commit_valid/arch/phys/prev    retirement update and register to free
//   flush                          recovery: restore from retirement state
//   free_count                     number of free physical registers
//   double_free_err                sticky: commit freed an already-free register
module register_rename_unit #(
  parameter int unsigned ARCH_REGS = 32,
  parameter int unsigned PHYS_REGS = 64,
  localparam int unsigned AW = $clog2(ARCH_REGS),
  localparam int unsigned PW = $clog2(PHYS_REGS),
  localparam int unsigned CW = $clog2(PHYS_REGS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          uses_rs,
  input  logic          uses_rt,
  input  logic          uses_rw,
  input  logic [AW-1:0] rs_addr,
  input  logic [AW-1:0] rt_addr,
  input  logic [AW-1:0] rw_addr,
  output logic [PW-1:0] out_rs_phys,
  output logic [PW-1:0] out_rt_phys,
  output logic [PW-1:0] out_rw_phys,
  output logic [PW-1:0] out_prev_phys,
  input  logic          commit_valid,
  input  logic [AW-1:0] commit_arch,
  input  logic [PW-1:0] commit_phys,
  input  logic [PW-1:0] commit_prev_phys,
  input  logic          flush,
  output logic [CW-1:0] free_count,
  output logic          double_free_err
);

  logic [PW-1:0]        spec_map_q [ARCH_REGS];
  logic [PW-1:0]        spec_map_d [ARCH_REGS];
  logic [PW-1:0]        ret_map_q  [ARCH_REGS];
  logic [PW-1:0]        ret_map_d  [ARCH_REGS];
  logic [PHYS_REGS-1:0] free_vec_q, free_vec_d;
  logic [CW-1:0]        free_count_q, free_count_d;
  logic                 dfe_q, dfe_d;

  logic                 needs_alloc;
  logic                 fire;
  logic                 commit_eff;
  logic                 dbl_free;
  logic                 free_eff;
  logic                 alloc_found;
  logic [PW-1:0]        alloc_idx;

  // Lowest-index free physical register.
  always_comb begin
    alloc_idx   = '0;
    alloc_found = 1'b0;
    for (int unsigned p = 0; p < PHYS_REGS; p++) begin
      if (free_vec_q[p] && !alloc_found) begin
        alloc_idx   = PW'(p);
        alloc_found = 1'b1;
      end
    end
  end

  assign needs_alloc = in_valid && uses_rw && (rw_addr != '0);
  assign in_ready    = !flush && (!needs_alloc || (free_count_q != '0));
  assign fire        = in_valid && in_ready && needs_alloc;

  assign commit_eff  = commit_valid && (commit_arch != '0);
  assign dbl_free    = commit_eff && free_vec_q[commit_prev_phys];
  assign free_eff    = commit_eff && !dbl_free;

  // Lookups use the pre-edge map, so a source equal to rw sees the old mapping.
  assign out_rs_phys     = uses_rs ? spec_map_q[rs_addr] : '0;
  assign out_rt_phys     = uses_rt ? spec_map_q[rt_addr] : '0;
  assign out_rw_phys     = fire ? alloc_idx : '0;
  assign out_prev_phys   = spec_map_q[rw_addr];
  assign free_count      = free_count_q;
  assign double_free_err = dfe_q;

  always_comb begin
    spec_map_d   = spec_map_q;
    ret_map_d    = ret_map_q;
    free_vec_d   = free_vec_q;
    free_count_d = free_count_q;
    dfe_d        = dfe_q || dbl_free;

    if (commit_eff) begin
      ret_map_d[commit_arch] = commit_phys;
    end

    if (flush) begin
      // Rebuild from the retirement map including this cycle's commit; every
      // register not referenced by it is free. No rename fires during flush.
      spec_map_d = ret_map_d;
      free_vec_d = '1;
      for (int unsigned a = 0; a < ARCH_REGS; a++) begin
        free_vec_d[ret_map_d[a]] = 1'b0;
      end
      free_count_d = '0;
      for (int unsigned p = 0; p < PHYS_REGS; p++) begin
        free_count_d = free_count_d + CW'(free_vec_d[p]);
      end
    end else begin
      if (free_eff) begin
        free_vec_d[commit_prev_phys] = 1'b1;
      end
      // alloc_idx is free pre-edge while a freed register was not, so the two
      // updates never touch the same bit.
      if (fire) begin
        spec_map_d[rw_addr]   = alloc_idx;
        free_vec_d[alloc_idx] = 1'b0;
      end
      case ({free_eff, fire})
        2'b10:   free_count_d = free_count_q + CW'(1);
        2'b01:   free_count_d = free_count_q - CW'(1);
        default: free_count_d = free_count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ARCH_REGS; i++) begin
        spec_map_q[i] <= PW'(i);
        ret_map_q[i]  <= PW'(i);
      end
      for (int unsigned p = 0; p < PHYS_REGS; p++) begin
        free_vec_q[p] <= (p >= ARCH_REGS);
      end
      free_count_q <= CW'(PHYS_REGS - ARCH_REGS);
      dfe_q        <= 1'b0;
    end else begin
      spec_map_q   <= spec_map_d;
      ret_map_q    <= ret_map_d;
      free_vec_q   <= free_vec_d;
      free_count_q <= free_count_d;
      dfe_q        <= dfe_d;
    end
  end

endmodule
